rob_nway: RTL and testbench
===========================

Name: rob_nway

Overview:
- Parametrised N-way reorder buffer. Successor to the fixed 3-wide, 32-entry ROB.
- Sits between dispatch and retire/architectural-map update.
- Accepts up to WIDTH in-order dispatches per cycle and takes WIDTH completion reports per cycle.
- Retires up to WIDTH consecutive completed entries from head.
- New behaviour: detects branch mispredicts at completion, stops retirement at the mispredicted entry, and self-flushes with a registered squash and recovery PC. Predictor training is emitted at retire.

Parameters:
- DEPTH, 32, number of entries; power of two, >= 2*WIDTH.
- WIDTH, 3, dispatch/complete/retire lanes; 1..4.
- XLEN, 32, PC width.
- IDX_W, $clog2(DEPTH), entry index width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- dispatch_valid  in  WIDTH  per-lane dispatch request; lane 0 oldest; valid lanes contiguous from lane 0
- dispatch_packet  in  WIDTH x ROB_ENTRY_PACKET  entry payload: PC, NPC, predict_taken, predict_target, is_branch, dest tags
- struct_stall  out  WIDTH  bit k=1: lane k cannot be accepted this cycle
- dispatch_index  out  WIDTH x IDX_W  entry index allocated to each accepted lane; 0 for unaccepted lanes
- complete_valid  in  WIDTH  completion report valid
- complete_idx  in  WIDTH x IDX_W  entry being completed
- complete_taken  in  WIDTH  resolved branch direction
- complete_target  in  WIDTH x XLEN  resolved branch target
- retire_valid  out  WIDTH  lane k retires this cycle; contiguous from lane 0
- retire_packet  out  WIDTH x ROB_ENTRY_PACKET  retired entry contents; 0 when not valid
- squash  out  1  registered one-cycle pulse: pipeline flush
- squash_pc  out  XLEN  recovery fetch PC, valid with squash
- bp_update_en  out  1  a retiring branch is present this cycle (oldest one only)
- bp_update_pc, bp_update_taken, bp_update_target  out  XLEN/1/XLEN  predictor training data

Behaviour:
- Clocking/reset: single clock. Reset is synchronous, active-high.
- Reset values: head=tail=count=0, all entry valid/completed=0. All outputs 0 except struct_stall, which is 0 whenever count=0.
- Occupancy: count register, IDX_W+1 bits.
  - free = DEPTH - count, from the registered count only; no same-cycle retire forwarding.
  - struct_stall[k]=1 iff k >= free.
- Dispatch:
  - Accepted lanes are written at tail+k (mod DEPTH) at the clock edge, with valid=1 and completed=0.
  - dispatch_index is combinational in the same cycle.
  - tail advances by the number accepted. Wrap-around is modulo DEPTH.
- Completion:
  - Applies only if the entry is valid; otherwise ignored. Sets completed.
  - mispredict = is_branch & ((taken != predict_taken) | (taken & target != predict_target)).
  - Stored recover_pc = taken ? target : NPC. Also stores resolved direction and target.
  - Visible for retire the cycle after completion; no same-cycle complete-to-retire bypass.
- Retire:
  - Lane k retires iff entries head..head+k are all valid & completed, and no entry at lanes <k is mispredicted.
  - A mispredicted entry does retire; younger lanes in the same group do not.
  - head += retired count. Retired entries are cleared.
- count_next = count + accepted - retired.
- Squash:
  - If a retiring entry is mispredicted at cycle t, then at edge t+1: all entries invalid, head=tail=count=0, squash=1 for cycle t+1, squash_pc = that entry's recover_pc.
  - Dispatches in cycle t are discarded: not written, and dispatch_index still reported.
  - squash deasserts at t+2 unless another squash occurs.
- Branch predictor update: bp_update_* reflects the oldest retiring branch in the group; 0 otherwise.
- Simultaneous events:
  - Full (count=DEPTH) with retire in the same cycle: no dispatch that cycle.
  - Duplicate complete_idx across lanes: the highest lane's data wins.
  - Reset overrides squash and dispatch.
- Latency: dispatch to earliest retire is 2 cycles (dispatch edge, completion edge, retire next cycle).

Decomposition:
- rob_pkg holds:
  - ROB_ENTRY_PACKET: valid, completed, PC, NPC, is_branch, predict_taken, predict_target, mispredict, resolved_taken, resolved_target, recover_pc, dest tags.
  - Defaults for DEPTH/WIDTH/XLEN.
- Sub-module rob_retire_select: combinational prefix scan over WIDTH head entries. Produces the retire_valid mask, retire count, squash-request flag, and oldest-branch select.

Test Plan:
- Reset, then dispatch 3/cycle for 11 cycles with DEPTH=32 -> count=32 and dispatch_index wraps 30,31,0; struct_stall=111 once count=32.
- Fill to count=30 with no completions, dispatch 3 -> struct_stall=100, only lanes 0,1 accepted, tail +2.
- Complete entries 0,1,2 in one cycle -> next cycle retire_valid=111, head=3, count-=3; completing entry 1 only -> no retire, since head is not completed.
- Branch at entry 5: predict_taken=0, complete_taken=1, target=0x1000; entries 5,6 completed -> retire lane 0 only (entry 5); next cycle squash=1, squash_pc=0x1000, count=0, and bp_update_en=1 in the retire cycle.
- Branch predict_taken=1, predict_target=0x200, resolved taken with target 0x300 -> squash_pc=0x300. Resolved not-taken with NPC=0x48 -> squash_pc=0x48.
- Assert reset mid-stream with dispatch_valid=111 and a pending mispredict retire -> next cycle count=0, squash=0, all outputs 0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types for the N-way reorder buffer.
// Holds the per-entry payload struct, default sizing and the mispredict check.
package rob_pkg;

  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned WIDTH_DEF = 3;
  localparam int unsigned ROB_XLEN  = 32;
  localparam int unsigned TAG_W     = 6;

  // One ROB slot; dispatch fills the front-end fields, completion the resolved ones.
  typedef struct packed {
    logic                valid;
    logic                completed;
    logic [ROB_XLEN-1:0] pc;
    logic [ROB_XLEN-1:0] npc;
    logic                is_branch;
    logic                predict_taken;
    logic [ROB_XLEN-1:0] predict_target;
    logic                mispredict;
    logic                resolved_taken;
    logic [ROB_XLEN-1:0] resolved_target;
    logic [ROB_XLEN-1:0] recover_pc;
    logic [TAG_W-1:0]    dest_tag;
    logic [TAG_W-1:0]    dest_old_tag;
  } rob_entry_packet_t;

  // Wrong direction, or right direction (taken) but wrong target.
  function automatic logic calc_mispredict(input rob_entry_packet_t e,
                                           input logic taken,
                                           input logic [ROB_XLEN-1:0] target);
    return e.is_branch &
           ((taken != e.predict_taken) | (taken & (target != e.predict_target)));
  endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Prefix scan over the WIDTH oldest entries.
// In : per-lane valid/completed/mispredict/is_branch, lane 0 = head.
// Out: retire mask and count, squash request and its lane, oldest retiring branch.
module rob_retire_select #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned LANE_W = 2,
  parameter int unsigned RCNT_W = 2
) (
  input  logic [WIDTH-1:0]  ent_valid,
  input  logic [WIDTH-1:0]  ent_completed,
  input  logic [WIDTH-1:0]  ent_mispredict,
  input  logic [WIDTH-1:0]  ent_is_branch,
  output logic [WIDTH-1:0]  retire_mask_c,
  output logic [RCNT_W-1:0] retire_cnt_c,
  output logic              squash_req_c,
  output logic [LANE_W-1:0] squash_lane_c,
  output logic              br_valid_c,
  output logic [LANE_W-1:0] br_lane_c
);

  logic open;

  // A lane retires while the run of completed entries is unbroken and no
  // older lane in the group was a mispredict; the mispredict itself retires.
  always_comb begin
    retire_mask_c = '0;
    retire_cnt_c  = '0;
    squash_req_c  = 1'b0;
    squash_lane_c = '0;
    br_valid_c    = 1'b0;
    br_lane_c     = '0;
    open          = 1'b1;
    for (int k = 0; k < int'(WIDTH); k++) begin
      if (open && ent_valid[k] && ent_completed[k]) begin
        retire_mask_c[k] = 1'b1;
        retire_cnt_c     = retire_cnt_c + RCNT_W'(1);
        if (!br_valid_c && ent_is_branch[k]) begin
          br_valid_c = 1'b1;
          br_lane_c  = LANE_W'(k);
        end
        if (ent_mispredict[k]) begin
          squash_req_c  = 1'b1;
          squash_lane_c = LANE_W'(k);
          open          = 1'b0;
        end
      end else begin
        open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer with mispredict self-flush.
// Dispatch: dispatch_valid/packet in, struct_stall/dispatch_index out (comb).
// Complete: complete_valid/idx/taken/target in.
// Retire:   retire_valid/packet out (comb from state), bp_update_* for the
//           oldest retiring branch, registered squash/squash_pc pulse.
module rob_nway
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned XLEN  = ROB_XLEN,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [WIDTH-1:0]                 dispatch_valid,
  input  rob_entry_packet_t [WIDTH-1:0]    dispatch_packet,
  output logic [WIDTH-1:0]                 struct_stall,
  output logic [WIDTH-1:0][IDX_W-1:0]      dispatch_index,
  input  logic [WIDTH-1:0]                 complete_valid,
  input  logic [WIDTH-1:0][IDX_W-1:0]      complete_idx,
  input  logic [WIDTH-1:0]                 complete_taken,
  input  logic [WIDTH-1:0][XLEN-1:0]       complete_target,
  output logic [WIDTH-1:0]                 retire_valid,
  output rob_entry_packet_t [WIDTH-1:0]    retire_packet,
  output logic                             squash,
  output logic [XLEN-1:0]                  squash_pc,
  output logic                             bp_update_en,
  output logic [XLEN-1:0]                  bp_update_pc,
  output logic                             bp_update_taken,
  output logic [XLEN-1:0]                  bp_update_target
);

  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned LANE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RCNT_W = $clog2(WIDTH + 1);

  rob_entry_packet_t mem_q [DEPTH];
  rob_entry_packet_t mem_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              squash_q, squash_d;
  logic [XLEN-1:0]   squash_pc_q, squash_pc_d;

  rob_entry_packet_t head_ent [WIDTH];
  logic [WIDTH-1:0]  hv, hc, hm, hb;
  logic [WIDTH-1:0]  accept;
  logic [RCNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0]  free_c;

  logic [WIDTH-1:0]  ret_mask;
  logic [RCNT_W-1:0] ret_cnt;
  logic              sq_req;
  logic [LANE_W-1:0] sq_lane;
  logic              br_valid;
  logic [LANE_W-1:0] br_lane;

  // Retire window: the WIDTH oldest slots starting at head.
  always_comb begin
    for (int k = 0; k < int'(WIDTH); k++) begin
      head_ent[k] = mem_q[head_q + IDX_W'(k)];
      hv[k]       = head_ent[k].valid;
      hc[k]       = head_ent[k].completed;
      hm[k]       = head_ent[k].mispredict;
      hb[k]       = head_ent[k].is_branch;
    end
  end

  rob_retire_select #(
    .WIDTH  (WIDTH),
    .LANE_W (LANE_W),
    .RCNT_W (RCNT_W)
  ) u_sel (
    .ent_valid      (hv),
    .ent_completed  (hc),
    .ent_mispredict (hm),
    .ent_is_branch  (hb),
    .retire_mask_c  (ret_mask),
    .retire_cnt_c   (ret_cnt),
    .squash_req_c   (sq_req),
    .squash_lane_c  (sq_lane),
    .br_valid_c     (br_valid),
    .br_lane_c      (br_lane)
  );

  // Free space comes from the registered count only, so a full ROB never
  // accepts in the same cycle it retires.
  always_comb begin
    free_c  = CNT_W'(DEPTH) - count_q;
    acc_cnt = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      struct_stall[k]   = (CNT_W'(k) >= free_c);
      accept[k]         = dispatch_valid[k] & ~struct_stall[k];
      dispatch_index[k] = accept[k] ? (tail_q + IDX_W'(k)) : '0;
      if (accept[k]) acc_cnt = acc_cnt + RCNT_W'(1);
    end
  end

  // Retire-side outputs straight from the head window.
  always_comb begin
    for (int k = 0; k < int'(WIDTH); k++) begin
      retire_packet[k] = ret_mask[k] ? head_ent[k] : '0;
    end
    retire_valid     = ret_mask;
    bp_update_en     = br_valid;
    bp_update_pc     = br_valid ? head_ent[br_lane].pc              : '0;
    bp_update_taken  = br_valid ? head_ent[br_lane].resolved_taken  : 1'b0;
    bp_update_target = br_valid ? head_ent[br_lane].resolved_target : '0;
    squash           = squash_q;
    squash_pc        = squash_pc_q;
  end

  // Next state: completions, then retire clears, then dispatch writes; a
  // retiring mispredict overrides all of it with an empty ROB.
  always_comb begin
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    squash_d    = 1'b0;
    squash_pc_d = '0;

    // Later lanes overwrite earlier ones on a duplicate index.
    for (int k = 0; k < int'(WIDTH); k++) begin
      if (complete_valid[k] && mem_q[complete_idx[k]].valid) begin
        mem_d[complete_idx[k]].completed       = 1'b1;
        mem_d[complete_idx[k]].resolved_taken  = complete_taken[k];
        mem_d[complete_idx[k]].resolved_target = complete_target[k];
        mem_d[complete_idx[k]].mispredict      =
          calc_mispredict(mem_q[complete_idx[k]], complete_taken[k], complete_target[k]);
        mem_d[complete_idx[k]].recover_pc      =
          complete_taken[k] ? complete_target[k] : mem_q[complete_idx[k]].npc;
      end
    end

    for (int k = 0; k < int'(WIDTH); k++) begin
      if (ret_mask[k]) mem_d[head_q + IDX_W'(k)] = '0;
    end
    head_d = head_q + IDX_W'(ret_cnt);

    for (int k = 0; k < int'(WIDTH); k++) begin
      if (accept[k]) begin
        mem_d[tail_q + IDX_W'(k)]                 = dispatch_packet[k];
        mem_d[tail_q + IDX_W'(k)].valid           = 1'b1;
        mem_d[tail_q + IDX_W'(k)].completed       = 1'b0;
        mem_d[tail_q + IDX_W'(k)].mispredict      = 1'b0;
        mem_d[tail_q + IDX_W'(k)].resolved_taken  = 1'b0;
        mem_d[tail_q + IDX_W'(k)].resolved_target = '0;
        mem_d[tail_q + IDX_W'(k)].recover_pc      = '0;
      end
    end
    tail_d  = tail_q + IDX_W'(acc_cnt);
    count_d = count_q + CNT_W'(acc_cnt) - CNT_W'(ret_cnt);

    if (sq_req) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      squash_d    = 1'b1;
      squash_pc_d = head_ent[sq_lane].recover_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      squash_q    <= 1'b0;
      squash_pc_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      squash_q    <= squash_d;
      squash_pc_q <= squash_pc_d;
    end
  end

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway with a retire/squash/predictor-update scoreboard.
module tb_rob_nway;
  import rob_pkg::*;

  localparam int unsigned W  = 3;
  localparam int unsigned IW = 5;
  localparam int unsigned XL = 32;

  logic                          clock = 1'b0;
  logic                          reset;
  logic [W-1:0]                  dispatch_valid;
  rob_entry_packet_t [W-1:0]     dispatch_packet;
  logic [W-1:0]                  struct_stall;
  logic [W-1:0][IW-1:0]          dispatch_index;
  logic [W-1:0]                  complete_valid;
  logic [W-1:0][IW-1:0]          complete_idx;
  logic [W-1:0]                  complete_taken;
  logic [W-1:0][XL-1:0]          complete_target;
  logic [W-1:0]                  retire_valid;
  rob_entry_packet_t [W-1:0]     retire_packet;
  logic                          squash;
  logic [XL-1:0]                 squash_pc;
  logic                          bp_update_en;
  logic [XL-1:0]                 bp_update_pc;
  logic                          bp_update_taken;
  logic [XL-1:0]                 bp_update_target;

  int total = 0;
  int bad   = 0;
  logic [31:0] ret_q [$];
  logic [31:0] sq_q  [$];
  logic [64:0] bp_q  [$];

  always #5 clock = ~clock;

  rob_nway dut (
    .clock            (clock),
    .reset            (reset),
    .dispatch_valid   (dispatch_valid),
    .dispatch_packet  (dispatch_packet),
    .struct_stall     (struct_stall),
    .dispatch_index   (dispatch_index),
    .complete_valid   (complete_valid),
    .complete_idx     (complete_idx),
    .complete_taken   (complete_taken),
    .complete_target  (complete_target),
    .retire_valid     (retire_valid),
    .retire_packet    (retire_packet),
    .squash           (squash),
    .squash_pc        (squash_pc),
    .bp_update_en     (bp_update_en),
    .bp_update_pc     (bp_update_pc),
    .bp_update_taken  (bp_update_taken),
    .bp_update_target (bp_update_target)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got=event want=none", nm);
  endtask

  function automatic rob_entry_packet_t mkp(input logic [31:0] pc, input logic br,
                                            input logic pt, input logic [31:0] ptgt);
    rob_entry_packet_t p;
    p                = '0;
    p.pc             = pc;
    p.npc            = pc + 32'd4;
    p.is_branch      = br;
    p.predict_taken  = pt;
    p.predict_target = ptgt;
    p.dest_tag       = pc[7:2];
    return p;
  endfunction

  task automatic idle();
    dispatch_valid  = '0;
    dispatch_packet = '0;
    complete_valid  = '0;
    complete_idx    = '0;
    complete_taken  = '0;
    complete_target = '0;
  endtask

  task automatic begin_cycle();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic chk_idx(input string nm, input int i0, input int i1, input int i2);
    chk({nm, "_idx0"}, 64'(dispatch_index[0]), 64'(i0));
    chk({nm, "_idx1"}, 64'(dispatch_index[1]), 64'(i1));
    chk({nm, "_idx2"}, 64'(dispatch_index[2]), 64'(i2));
  endtask

  task automatic cmp(input int lane, input logic [4:0] idx, input logic tk, input logic [31:0] tgt);
    complete_valid[lane]  = 1'b1;
    complete_idx[lane]    = idx;
    complete_taken[lane]  = tk;
    complete_target[lane] = tgt;
  endtask

  // Monitor: every retired lane, squash pulse and predictor update pops its queue.
  always @(negedge clock) begin
    for (int k = 0; k < int'(W); k++) begin
      if (retire_valid[k]) begin
        if (ret_q.size() == 0) unexpected($sformatf("retire_lane%0d", k));
        else chk($sformatf("retire_pc_lane%0d", k), 64'(retire_packet[k].pc), 64'(ret_q.pop_front()));
      end
    end
    if (squash) begin
      if (sq_q.size() == 0) unexpected("squash");
      else chk("squash_pc", 64'(squash_pc), 64'(sq_q.pop_front()));
    end
    if (bp_update_en) begin
      if (bp_q.size() == 0) unexpected("bp_update");
      else begin
        logic [64:0] e;
        e = bp_q.pop_front();
        chk("bp_pc", 64'(bp_update_pc), 64'(e[64:33]));
        chk("bp_taken", 64'(bp_update_taken), 64'(e[32]));
        chk("bp_target", 64'(bp_update_target), 64'(e[31:0]));
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_stall", 64'(struct_stall), 64'h0);
    chk("rst_retire", 64'(retire_valid), 64'h0);
    chk("rst_squash", 64'(squash), 64'h0);
    chk("rst_bp", 64'(bp_update_en), 64'h0);
    chk_idx("rst", 0, 0, 0);

    // Fill: 3 per cycle; the 11th cycle only has room for two.
    for (int i = 0; i < 11; i++) begin
      begin_cycle();
      dispatch_valid = 3'b111;
      for (int k = 0; k < 3; k++)
        dispatch_packet[k] = mkp(32'h8000 + 32'(4 * (3 * i + k)), (3 * i + k) == 5, 1'b0, 32'h0);
      @(negedge clock);
      if (i < 10) begin
        chk("fill_stall", 64'(struct_stall), 64'b000);
        chk_idx("fill", 3 * i, 3 * i + 1, 3 * i + 2);
      end else begin
        chk("fill_stall_last", 64'(struct_stall), 64'b100);
        chk_idx("fill_last", 30, 31, 0);
      end
    end

    begin_cycle();
    dispatch_valid = 3'b111;
    @(negedge clock);
    chk("full_stall", 64'(struct_stall), 64'b111);
    chk_idx("full", 0, 0, 0);

    begin_cycle();
    cmp(0, 5'd0, 1'b0, 32'h0);
    cmp(1, 5'd1, 1'b0, 32'h0);
    cmp(2, 5'd2, 1'b0, 32'h0);
    ret_q.push_back(32'h8000); ret_q.push_back(32'h8004); ret_q.push_back(32'h8008);

    // Full and retiring in the same cycle: still stalled.
    begin_cycle();
    dispatch_valid = 3'b111;
    @(negedge clock);
    chk("ret3_valid", 64'(retire_valid), 64'b111);
    chk("ret3_stall", 64'(struct_stall), 64'b111);
    chk_idx("ret3", 0, 0, 0);

    begin_cycle();
    dispatch_valid = 3'b111;
    for (int k = 0; k < 3; k++) dispatch_packet[k] = mkp(32'h8080 + 32'(4 * k), 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    chk("wrap_stall", 64'(struct_stall), 64'b000);
    chk_idx("wrap", 0, 1, 2);

    begin_cycle();
    cmp(0, 5'd4, 1'b0, 32'h0);
    begin_cycle();
    @(negedge clock);
    chk("nohead_retire", 64'(retire_valid), 64'b000);

    begin_cycle();
    cmp(0, 5'd3, 1'b0, 32'h0);
    ret_q.push_back(32'h800C); ret_q.push_back(32'h8010);

    begin_cycle();
    cmp(0, 5'd5, 1'b1, 32'h1000);
    cmp(1, 5'd6, 1'b0, 32'h0);
    ret_q.push_back(32'h8014);
    bp_q.push_back({32'h8014, 1'b1, 32'h1000});
    sq_q.push_back(32'h1000);
    @(negedge clock);
    chk("ret2_valid", 64'(retire_valid), 64'b011);
    chk("ret2_squash", 64'(squash), 64'h0);

    // Mispredict retires alone; dispatch this cycle is reported but dropped.
    begin_cycle();
    dispatch_valid = 3'b111;
    @(negedge clock);
    chk("mis_retire", 64'(retire_valid), 64'b001);
    chk("mis_bp_en", 64'(bp_update_en), 64'h1);
    chk("mis_stall", 64'(struct_stall), 64'b100);
    chk_idx("mis", 3, 4, 0);

    begin_cycle();
    dispatch_valid = 3'b111;
    dispatch_packet[0] = mkp(32'h40, 1'b1, 1'b1, 32'h200);
    dispatch_packet[1] = mkp(32'h50, 1'b0, 1'b0, 32'h0);
    dispatch_packet[2] = mkp(32'h54, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    chk("sq1_squash", 64'(squash), 64'h1);
    chk("sq1_stall", 64'(struct_stall), 64'b000);
    chk("sq1_retire", 64'(retire_valid), 64'b000);
    chk_idx("sq1", 0, 1, 2);

    // Taken with wrong target: recover to the resolved target.
    begin_cycle();
    cmp(0, 5'd0, 1'b1, 32'h300);
    ret_q.push_back(32'h40);
    bp_q.push_back({32'h40, 1'b1, 32'h300});
    sq_q.push_back(32'h300);
    @(negedge clock);
    chk("sq1_off", 64'(squash), 64'h0);

    begin_cycle();
    @(negedge clock);
    chk("tgt_retire", 64'(retire_valid), 64'b001);

    begin_cycle();
    dispatch_valid = 3'b001;
    dispatch_packet[0] = mkp(32'h44, 1'b1, 1'b1, 32'h200);
    @(negedge clock);
    chk("sq2_squash", 64'(squash), 64'h1);
    chk_idx("sq2", 0, 0, 0);

    // Predicted taken, resolved not-taken: recover to NPC.
    begin_cycle();
    cmp(0, 5'd0, 1'b0, 32'h0);
    ret_q.push_back(32'h44);
    bp_q.push_back({32'h44, 1'b0, 32'h0});
    sq_q.push_back(32'h48);

    begin_cycle();
    @(negedge clock);
    chk("nt_retire", 64'(retire_valid), 64'b001);

    begin_cycle();
    dispatch_valid = 3'b111;
    dispatch_packet[0] = mkp(32'h60, 1'b0, 1'b0, 32'h0);
    dispatch_packet[1] = mkp(32'h64, 1'b1, 1'b0, 32'h0);
    dispatch_packet[2] = mkp(32'h68, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    chk("sq3_squash", 64'(squash), 64'h1);
    chk_idx("sq3", 0, 1, 2);

    // Duplicate index: lane 1 (correct prediction) beats lane 0.
    begin_cycle();
    cmp(0, 5'd1, 1'b1, 32'h500);
    cmp(1, 5'd1, 1'b0, 32'h0);
    cmp(2, 5'd0, 1'b0, 32'h0);
    ret_q.push_back(32'h60); ret_q.push_back(32'h64);
    bp_q.push_back({32'h64, 1'b0, 32'h0});

    begin_cycle();
    @(negedge clock);
    chk("dup_retire", 64'(retire_valid), 64'b011);
    chk("dup_squash", 64'(squash), 64'h0);

    begin_cycle();
    dispatch_valid = 3'b001;
    dispatch_packet[0] = mkp(32'h70, 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    chk("dup_nosquash", 64'(squash), 64'h0);
    chk_idx("pre_rst", 3, 0, 0);

    begin_cycle();
    cmp(0, 5'd2, 1'b0, 32'h0);
    cmp(1, 5'd3, 1'b1, 32'h900);
    ret_q.push_back(32'h68); ret_q.push_back(32'h70);
    bp_q.push_back({32'h70, 1'b1, 32'h900});

    // Reset lands on the cycle a mispredict retires: no squash may follow.
    begin_cycle();
    reset = 1'b1;
    dispatch_valid = 3'b111;
    @(negedge clock);
    chk("rstmid_retire", 64'(retire_valid), 64'b011);

    begin_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_squash", 64'(squash), 64'h0);
    chk("post_rst_sqpc", 64'(squash_pc), 64'h0);
    chk("post_rst_stall", 64'(struct_stall), 64'h0);
    chk("post_rst_retire", 64'(retire_valid), 64'h0);
    chk("post_rst_bp", 64'(bp_update_en), 64'h0);
    chk_idx("post_rst", 0, 0, 0);

    begin_cycle();
    dispatch_valid = 3'b111;
    @(negedge clock);
    chk("post_rst_disp_stall", 64'(struct_stall), 64'b000);
    chk_idx("post_rst_disp", 0, 1, 2);

    begin_cycle();
    @(negedge clock);
    chk("end_squash", 64'(squash), 64'h0);
    chk("ret_q_empty", 64'(ret_q.size()), 64'h0);
    chk("sq_q_empty", 64'(sq_q.size()), 64'h0);
    chk("bp_q_empty", 64'(bp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
